// File: rtl/vga_pmod_monitor.sv
// TinyVGA PMOD receiver: recovers sync timing from the registered bus, measures line and
// frame lengths, tracks lock, and reports active-area coordinates and a per-frame checksum.
module vga_pmod_monitor #(
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int H_ACTIVE    = 640,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  vga_in,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        pixel_valid,
   output logic [5:0]  pixel_rgb,
   output logic [10:0] line_len,
   output logic [10:0] frame_lines,
   output logic [15:0] checksum,
   output logic        frame_done,
   output logic        locked,
   output logic        err_sticky
);

   localparam logic [10:0] CNT_MAX = 11'h7FF;
   localparam logic [10:0] HT      = 11'(H_TOTAL);
   localparam logic [10:0] X0      = 11'(H_SYNC + H_BACK);
   localparam logic [10:0] X1      = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
   localparam logic [10:0] VT      = 11'(V_TOTAL);
   localparam logic [10:0] Y0      = 11'(V_SYNC + V_BACK);
   localparam logic [10:0] Y1      = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);
   localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      return (v == CNT_MAX) ? CNT_MAX : v + 11'd1;
   endfunction

   state_t      state, state_nxt;
   logic [7:0]  s;
   logic        s_vld, hs_prev, vs_prev;
   logic        h_edge, v_edge;
   logic [10:0] hcnt, vcnt, hlen, vlen;
   logic [15:0] chk;
   logic [2:0]  gcnt, gcnt_nxt, gcnt_inc;
   logic        h_seen, frame_bad;
   logic        h_bad, v_bad, sat_hit, err_set;
   logic        h_act, v_act;

   // Input stage; the first post-reset sample seeds the history so a low sync is not an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s       <= 8'h00;
         s_vld   <= 1'b0;
         hs_prev <= 1'b1;
         vs_prev <= 1'b1;
      end else begin
         s       <= vga_in;
         s_vld   <= 1'b1;
         hs_prev <= s_vld ? s[7] : vga_in[7];
         vs_prev <= s_vld ? s[3] : vga_in[3];
      end
   end

   assign h_edge  = s_vld & hs_prev & ~s[7];
   assign v_edge  = s_vld & vs_prev & ~s[3];
   assign hlen    = sat_inc(hcnt);
   assign vlen    = sat_inc(vcnt);
   assign h_bad   = h_edge & h_seen & (hlen != HT);
   assign v_bad   = (vlen != VT);
   assign sat_hit = (hcnt == CNT_MAX);

   assign pixel_rgb   = {s[0], s[4], s[1], s[5], s[2], s[6]};
   assign h_act       = (hcnt >= X0) && (hcnt <= X1);
   assign v_act       = (vcnt >= Y0) && (vcnt <= Y1);
   assign pixel_valid = h_act & v_act;
   assign pixel_x     = pixel_valid ? 10'(hcnt - X0) : 10'd0;
   assign pixel_y     = pixel_valid ? 10'(vcnt - Y0) : 10'd0;

   // Timing counters, measurements and checksum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt        <= 11'd0;
         vcnt        <= 11'd0;
         line_len    <= 11'd0;
         frame_lines <= 11'd0;
         checksum    <= 16'h0000;
         chk         <= 16'h0000;
         frame_done  <= 1'b0;
         h_seen      <= 1'b0;
         frame_bad   <= 1'b0;
      end else begin
         frame_done <= v_edge;
         if (h_edge) begin
            hcnt   <= 11'd0;
            h_seen <= 1'b1;
            if (h_seen) line_len <= hlen;
         end else begin
            hcnt <= sat_inc(hcnt);
         end
         if (v_edge) begin
            vcnt <= 11'd0;
            chk  <= 16'h0000;
            // The first vsync only opens a measurement window
            if (state != SEARCH) begin
               frame_lines <= vlen;
               checksum    <= chk;
            end
         end else begin
            if (h_edge) vcnt <= sat_inc(vcnt);
            if (pixel_valid) chk <= {chk[14:0], chk[15]} ^ {10'b0, pixel_rgb};
         end
         if (v_edge)     frame_bad <= 1'b0;
         else if (h_bad) frame_bad <= 1'b1;
      end
   end

   // Lock FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= SEARCH;
         gcnt       <= 3'd0;
         err_sticky <= 1'b0;
      end else begin
         state <= state_nxt;
         gcnt  <= gcnt_nxt;
         if (err_set) err_sticky <= 1'b1;
      end
   end

   assign gcnt_inc = gcnt + 3'd1;

   // A frame is clean when no line in it, including the one closed by this vsync, was off-length
   always_comb begin
      state_nxt = state;
      gcnt_nxt  = gcnt;
      err_set   = 1'b0;
      case (state)
         SEARCH: begin
            if (v_edge) begin
               state_nxt = TRAIN;
               gcnt_nxt  = 3'd0;
            end
         end
         TRAIN: begin
            if (v_edge) begin
               if (!frame_bad && !h_bad && !v_bad) begin
                  gcnt_nxt = gcnt_inc;
                  if (gcnt_inc == LOCK_N) state_nxt = LOCKED;
               end else begin
                  gcnt_nxt = 3'd0;
               end
            end
         end
         LOCKED: begin
            if (h_bad || (v_edge && v_bad) || sat_hit) begin
               state_nxt = TRAIN;
               gcnt_nxt  = 3'd0;
               err_set   = 1'b1;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_pmod_monitor.sv
// Bench for vga_pmod_monitor: small-timing PMOD streams with random colours, checked every cycle
// against a timestamp-based reference model plus directed probes at lock, error and saturation points.
module tb_vga_pmod_monitor;

   localparam int HT = 20, HS = 3, HB = 2, HA = 12;
   localparam int VT = 12, VS = 1, VB = 2, VA = 8;
   localparam int LF = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  vga_in = 8'h88;
   logic [9:0]  pixel_x, pixel_y;
   logic        pixel_valid;
   logic [5:0]  pixel_rgb;
   logic [10:0] line_len, frame_lines;
   logic [15:0] checksum;
   logic        frame_done, locked, err_sticky;

   vga_pmod_monitor #(
      .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
      .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk), .rst(rst), .vga_in(vga_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb),
      .line_len(line_len), .frame_lines(frame_lines), .checksum(checksum),
      .frame_done(frame_done), .locked(locked), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int pv_cnt   = 0;

   // Reference model: sample times of sync edges and per-frame accumulators
   int          t, last_h, hsince, run;
   bit          prev_hs, prev_vs, h_seen, v_seen, lock_m, err_m, fbad, fd_m;
   int          ll_m, fl_m;
   logic [15:0] cs_m, chk_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 2047) ? 2047 : v;
   endfunction

   function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
      logic [15:0] r = x;
      for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
      return r;
   endfunction

   task automatic model_reset();
      t = 0; last_h = 0; hsince = 0; run = 0;
      prev_hs = 1'b1; prev_vs = 1'b1;
      h_seen = 0; v_seen = 0; lock_m = 0; err_m = 0; fbad = 0; fd_m = 0;
      ll_m = 0; fl_m = 0; cs_m = 16'h0000; chk_m = 16'h0000;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pixel_x"}, pixel_x, 0);
      check({tag, "_pixel_y"}, pixel_y, 0);
      check({tag, "_pixel_valid"}, pixel_valid, 0);
      check({tag, "_pixel_rgb"}, pixel_rgb, 0);
      check({tag, "_line_len"}, line_len, 0);
      check({tag, "_frame_lines"}, frame_lines, 0);
      check({tag, "_checksum"}, checksum, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_err_sticky"}, err_sticky, 0);
   endtask

   // Bus {hsync, b0, g0, r0, vsync, b1, g1, r1}; colour c is {r1,r0,g1,g0,b1,b0}.
   // The monitor's column 0 is the sample one past HS+HB in the line (hcnt lags the sample).
   function automatic logic [7:0] gen(input int l, input int p, input int mode);
      logic [5:0] c;
      case (mode)
         0:       c = 6'h00;
         1:       c = (l == VS + VB && p == HS + HB + 1) ? 6'h3F : 6'h00;
         default: c = 6'($urandom());
      endcase
      return {p >= HS, c[0], c[2], c[4], l >= VS, c[1], c[3], c[5]};
   endfunction

   task automatic step(input logic [7:0] v);
      int hc, vc, hlen, vlen;
      bit valid, hs, vs, hedge, vedge, hbad, was_seen;
      logic [5:0] rgb;
      vga_in = v;
      @(posedge clk);
      #1;
      t++;
      check("line_len", line_len, ll_m);
      check("frame_lines", frame_lines, fl_m);
      check("checksum", checksum, cs_m);
      check("frame_done", frame_done, fd_m);
      check("locked", locked, lock_m);
      check("err_sticky", err_sticky, err_m);
      hc = sat(t - 1 - last_h);
      vc = sat(hsince);
      valid = (hc >= HS + HB) && (hc < HS + HB + HA) && (vc >= VS + VB) && (vc < VS + VB + VA);
      rgb = {v[0], v[4], v[1], v[5], v[2], v[6]};
      check("pixel_valid", pixel_valid, valid);
      check("pixel_x", pixel_x, valid ? hc - (HS + HB) : 0);
      check("pixel_y", pixel_y, valid ? vc - (VS + VB) : 0);
      check("pixel_rgb", pixel_rgb, rgb);
      if (pixel_valid) pv_cnt++;
      hs = v[7];
      vs = v[3];
      hedge = (t >= 2) && prev_hs && !hs;
      vedge = (t >= 2) && prev_vs && !vs;
      hlen = sat(t - last_h);
      vlen = sat(hsince + 1);
      hbad = hedge && h_seen && (hlen != HT);
      was_seen = v_seen;
      if (lock_m) begin
         if (hbad || (vedge && vlen != VT) || hc == 2047) begin
            err_m = 1; lock_m = 0; run = 0;
         end
      end else if (v_seen) begin
         if (vedge) begin
            if (!fbad && !hbad && vlen == VT) begin
               run++;
               if (run == LF) lock_m = 1;
            end else begin
               run = 0;
            end
         end
      end else if (vedge) begin
         run = 0;
      end
      if (vedge) begin
         if (was_seen) begin
            fl_m = vlen;
            cs_m = chk_m;
         end
         chk_m = 16'h0000;
         hsince = 0;
         v_seen = 1;
      end else begin
         if (hedge) hsince++;
         if (valid) chk_m = {chk_m[14:0], chk_m[15]} ^ {10'b0, rgb};
      end
      if (hedge) begin
         if (h_seen) ll_m = hlen;
         h_seen = 1;
         last_h = t;
      end
      if (vedge) fbad = 0;
      else if (hbad) fbad = 1;
      fd_m = vedge;
      prev_hs = hs;
      prev_vs = vs;
   endtask

   task automatic send_frame(input int mode, input int nlines, input int short_l,
                             input int ll_line, input int ll_exp);
      int len;
      pv_cnt = 0;
      for (int l = 0; l < nlines; l++) begin
         len = (l == short_l) ? HT - 1 : HT;
         for (int p = 0; p < len; p++) begin
            step(gen(l, p, mode));
            if (l == ll_line && p == 1) check("line_len_probe", line_len, ll_exp);
         end
      end
      if (nlines == VT) check("pixel_valid_count", pv_cnt, HA * VA);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("init");
      rst = 1'b0;
      repeat (4) step(8'($urandom()) | 8'h88);
      send_frame(2, 5, -1, -1, 0);

      // Asynchronous reset mid-stream with both syncs low, released while they stay low
      vga_in = 8'h00;
      #2;
      rst = 1'b1;
      #1;
      check_zero("rst_async");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (6) step(8'h00);
      repeat (3) step(8'h88);

      // Nominal black frames: lock after the third vsync edge
      repeat (3) send_frame(0, VT, -1, -1, 0);
      check("nominal_locked", locked, 1);
      check("nominal_line_len", line_len, HT);
      check("nominal_frame_lines", frame_lines, VT);
      check("nominal_checksum", checksum, 16'h0000);
      check("nominal_err", err_sticky, 0);

      // Single lit pixel at (0,0), then a random frame publishes its checksum
      send_frame(1, VT, -1, -1, 0);
      send_frame(2, VT, -1, -1, 0);
      check("single_pixel_checksum", checksum, rotl(16'h003F, (HA * VA - 1) % 16));

      // One short line breaks lock; two clean frames relock with the error still sticky
      send_frame(2, VT, 5, 6, HT - 1);
      check("short_err", err_sticky, 1);
      check("short_unlocked", locked, 0);
      send_frame(2, VT, -1, -1, 0);
      send_frame(2, VT, -1, -1, 0);
      send_frame(2, 4, -1, -1, 0);
      check("relock", locked, 1);
      check("relock_err", err_sticky, 1);

      // hsync held high long enough to saturate the line counter
      repeat (3000) step(8'($urandom()) | 8'h88);
      check("sat_err", err_sticky, 1);
      check("sat_unlocked", locked, 0);
      send_frame(2, VT, -1, 0, 2047);
      send_frame(2, VT, -1, -1, 0);
      send_frame(2, 1, -1, -1, 0);
      check("final_locked", locked, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
